detect_run_logger: RTL and testbench

DETECT_RUN_LOGGER -- requirements
Module: detect_run_logger

---
 rtl/detect_run_logger.sv | 104 ++++++++++
 tb/tb_detect_run_logger.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/detect_run_logger.sv
// Logs the length of each run of det_in=1 into a small first-word-fall-through FIFO
// and counts detection events; both the run length and the event counter saturate.
module detect_run_logger #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          det_in,
  input  logic          clr,
  input  logic          rd_en,
  output logic [CW-1:0] rd_data,
  output logic          rd_valid,
  output logic          fifo_full,
  output logic [CW-1:0] event_count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] run_len_q, run_len_d;
  logic [CW-1:0] event_count_q, event_count_d;
  logic          overflow_q;
  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic empty, full, push, pop, do_write, drop;

  always_comb begin
    empty         = (count_q == '0);
    full          = (count_q == (AW+1)'(DEPTH));
    push          = (state_q == RUN) && !det_in;
    pop           = rd_en && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_write      = push && (!full || pop);
    drop          = push && full && !pop;
    run_len_d     = (run_len_q == '1) ? run_len_q : run_len_q + 1'b1;
    event_count_d = (event_count_q == '1) ? event_count_q : event_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      run_len_q     <= '0;
      event_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      state_q       <= IDLE;
      run_len_q     <= '0;
      event_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (det_in) begin
            state_q       <= RUN;
            run_len_q     <= CW'(1);
            event_count_q <= event_count_d;
          end
        end
        RUN: begin
          if (det_in) begin
            run_len_q <= run_len_d;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (do_write) begin
        mem_q[wr_ptr_q] <= run_len_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({do_write, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (drop) overflow_q <= 1'b1;
    end
  end

  assign rd_valid    = !empty;
  assign fifo_full   = full;
  assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign event_count = event_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_detect_run_logger.sv
// Directed bench for detect_run_logger: hand-computed run lengths, FIFO ordering,
// saturation, overflow and clear/reset behaviour.
module tb_detect_run_logger;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          det_in;
  logic          clr;
  logic          rd_en;
  logic [CW-1:0] rd_data;
  logic          rd_valid;
  logic          fifo_full;
  logic [CW-1:0] event_count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  detect_run_logger #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .det_in      (det_in),
    .clr         (clr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_full   (fifo_full),
    .event_count (event_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic d, input logic r, input logic c);
    det_in = d;
    rd_en  = r;
    clr    = c;
    @(posedge clk);
    #1;
    det_in = 1'b0;
    rd_en  = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic run(input int n, input logic rd_on_end);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, rd_on_end, 1'b0);
  endtask

  task automatic pop_check(input string tag, input int exp);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, exp);
    cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    det_in = 1'b0;
    clr    = 1'b0;
    rd_en  = 1'b0;
    #12;
    check("rst_data", rd_data, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", fifo_full, 0);
    check("rst_evt", event_count, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // single run of 3
    run(3, 1'b0);
    check("r3_evt", event_count, 1);
    check("r3_valid", rd_valid, 1);
    check("r3_data", rd_data, 3);
    cyc(1'b0, 1'b1, 1'b0);
    check("r3_popped", rd_valid, 0);
    check("r3_empty_data", rd_data, 0);

    // runs 1..5, fifth is dropped
    cyc(1'b0, 1'b0, 1'b1);
    for (int l = 1; l <= 5; l++) run(l, 1'b0);
    check("f5_full", fifo_full, 1);
    check("f5_ovf", overflow, 1);
    check("f5_evt", event_count, 5);
    pop_check("f5_p1", 1);
    pop_check("f5_p2", 2);
    pop_check("f5_p3", 3);
    pop_check("f5_p4", 4);
    check("f5_empty", rd_valid, 0);
    check("f5_ovf_sticky", overflow, 1);
    check("f5_evt_after", event_count, 5);

    // simultaneous push and pop when full
    cyc(1'b0, 1'b0, 1'b1);
    check("clr_ovf", overflow, 0);
    for (int l = 1; l <= 4; l++) run(l, 1'b0);
    check("pp_full_before", fifo_full, 1);
    run(7, 1'b1);
    check("pp_full", fifo_full, 1);
    check("pp_ovf", overflow, 0);
    pop_check("pp_p1", 2);
    pop_check("pp_p2", 3);
    pop_check("pp_p3", 4);
    pop_check("pp_p4", 7);
    check("pp_empty", rd_valid, 0);

    // push with rd_en on empty FIFO keeps the entry
    run(2, 1'b1);
    check("ep_valid", rd_valid, 1);
    check("ep_data", rd_data, 2);

    // long run saturates run length
    cyc(1'b0, 1'b0, 1'b1);
    run(300, 1'b0);
    check("sat_data", rd_data, 255);
    check("sat_evt", event_count, 1);
    cyc(1'b0, 1'b1, 1'b0);
    check("sat_single", rd_valid, 0);

    // event counter saturation, then clear
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) run(1, 1'b0);
    check("evs_evt", event_count, 255);
    check("evs_ovf", overflow, 1);
    check("evs_full", fifo_full, 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("evs_clr_evt", event_count, 0);
    check("evs_clr_ovf", overflow, 0);
    check("evs_clr_valid", rd_valid, 0);

    // clr wins over det_in and rd_en; run in progress discarded
    run(1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("cp_valid", rd_valid, 0);
    check("cp_evt", event_count, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("cp_nopush", rd_valid, 0);

    // async reset mid-run
    run(1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("ar_pre_valid", rd_valid, 1);
    check("ar_pre_evt", event_count, 2);
    det_in = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", rd_valid, 0);
    check("ar_evt", event_count, 0);
    check("ar_data", rd_data, 0);
    det_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    check("ar_after_valid", rd_valid, 0);
    check("ar_after_evt", event_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
